// File: rtl/memory_pkg.sv
// Shared definitions for the parametrised data memory: FSM states, default
// geometry and a constant-evaluable ceil(log2) helper.
package memory_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 32;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the datapath/controller and data_memory.
interface data_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemReadEn;
    logic              MemWriteEn;
    logic [DATA_W-1:0] ReadData;
    logic              ReadValid;
    logic              Busy;
    logic              AddrError;

    modport master (
        output Address, WriteData, MemReadEn, MemWriteEn,
        input  ReadData, ReadValid, Busy, AddrError
    );

    modport slave (
        input  Address, WriteData, MemReadEn, MemWriteEn,
        output ReadData, ReadValid, Busy, AddrError
    );
endinterface

// File: rtl/data_memory_clear_sequencer.sv
// Post-reset clear sequencer: walks every word once, writing zero, then
// releases the memory to the user port.
module clear_sequencer
    import memory_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic [IW-1:0] clr_addr,
    output logic          clr_we
);
    localparam int IDX_W = clog2(DEPTH) + 1;

    mem_state_t       state_r, state_s;
    logic [IDX_W-1:0] clr_idx_r, clr_idx_s;
    logic             clr_we_s;

    // state and index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= CLEAR;
            clr_idx_r <= '0;
        end else begin
            state_r   <= state_s;
            clr_idx_r <= clr_idx_s;
        end
    end

    // next-state and clear write strobe
    always_comb begin
        state_s   = state_r;
        clr_idx_s = clr_idx_r;
        clr_we_s  = 1'b0;
        case (state_r)
            CLEAR: begin
                clr_we_s = 1'b1;
                if (clr_idx_r == IDX_W'(DEPTH - 1)) begin
                    state_s   = READY;
                    clr_idx_s = '0;
                end else begin
                    clr_idx_s = clr_idx_r + IDX_W'(1);
                end
            end
            READY: begin
                clr_we_s = 1'b0;
            end
            default: begin
                state_s   = CLEAR;
                clr_idx_s = '0;
            end
        endcase
    end

    assign busy     = (state_r == CLEAR);
    assign clr_we   = clr_we_s;
    assign clr_addr = clr_idx_r[IW-1:0];

endmodule

// File: rtl/data_memory.sv
// Parametrised single-port data memory with registered read, post-reset clear
// and range checking. Optional macro DATA_MEMORY_WRITE_BYPASS_EN selects
// write-first forwarding on a same-cycle same-address read+write.
module data_memory
    import memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    data_memory_if.slave   bus
);
    localparam int IW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] read_data_r;
    logic              read_valid_r;
    logic              addr_error_r;

    logic              busy_s;
    logic [IW-1:0]     clr_addr_s;
    logic              clr_we_s;
    logic              in_range_s;
    logic [IW-1:0]     user_idx_s;
    logic              we_s;
    logic [IW-1:0]     widx_s;
    logic [DATA_W-1:0] wdata_s;

    clear_sequencer #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_clear_sequencer (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy_s),
        .clr_addr (clr_addr_s),
        .clr_we   (clr_we_s)
    );

    // full-width compare so high address bits never alias into the array
    assign in_range_s = ({1'b0, bus.Address} < (ADDR_W + 1)'(DEPTH));
    assign user_idx_s = IW'(bus.Address);

    // storage write-port mux: clear sequencer owns the array while busy
    always_comb begin
        we_s    = 1'b0;
        widx_s  = '0;
        wdata_s = '0;
        if (busy_s) begin
            we_s    = clr_we_s;
            widx_s  = clr_addr_s;
            wdata_s = '0;
        end else begin
            we_s    = bus.MemWriteEn && in_range_s;
            widx_s  = user_idx_s;
            wdata_s = bus.WriteData;
        end
    end

    // storage array write
    always_ff @(posedge clk) begin
        if (!rst && we_s) begin
            mem_r[widx_s] <= wdata_s;
        end
    end

    // registered read data and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_r  <= '0;
            read_valid_r <= 1'b0;
            addr_error_r <= 1'b0;
        end else begin
            read_valid_r <= 1'b0;
            addr_error_r <= 1'b0;
            if (!busy_s) begin
                if ((bus.MemReadEn || bus.MemWriteEn) && !in_range_s) begin
                    addr_error_r <= 1'b1;
                end else if (bus.MemReadEn) begin
                    read_valid_r <= 1'b1;
`ifdef DATA_MEMORY_WRITE_BYPASS_EN
                    if (bus.MemWriteEn) begin
                        read_data_r <= bus.WriteData;
                    end else begin
                        read_data_r <= mem_r[user_idx_s];
                    end
`else
                    read_data_r <= mem_r[user_idx_s];
`endif
                end
            end
        end
    end

    assign bus.ReadData  = read_data_r;
    assign bus.ReadValid = read_valid_r;
    assign bus.AddrError = addr_error_r;
    assign bus.Busy      = busy_s;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: default 8/8/32 geometry and a
// 16/4/10 instance.
module tb_data_memory;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycles;
    logic [7:0] exp_same;

    data_memory_if #(.DATA_W(8),  .ADDR_W(8)) bus_a ();
    data_memory_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

    data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(32)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    data_memory #(.DATA_W(16), .ADDR_W(4), .DEPTH(10)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        bus_a.MemReadEn  = rd;
        bus_a.MemWriteEn = wr;
        bus_a.Address    = addr;
        bus_a.WriteData  = wd;
    endtask

    task automatic req_b(input logic rd, input logic wr, input logic [3:0] addr, input logic [15:0] wd);
        bus_b.MemReadEn  = rd;
        bus_b.MemWriteEn = wr;
        bus_b.Address    = addr;
        bus_b.WriteData  = wd;
    endtask

    // counts Busy cycles; every busy cycle must show no ReadValid/AddrError
    task automatic count_busy_a(output int n);
        n = 0;
        while (bus_a.Busy === 1'b1 && n < 200) begin
            check("a_clear_flags", {30'd0, bus_a.ReadValid, bus_a.AddrError}, 32'd0);
            n++;
            tick();
        end
    endtask

    task automatic count_busy_b(output int n);
        n = 0;
        while (bus_b.Busy === 1'b1 && n < 200) begin
            check("b_clear_flags", {30'd0, bus_b.ReadValid, bus_b.AddrError}, 32'd0);
            n++;
            tick();
        end
    endtask

    initial begin
`ifdef DATA_MEMORY_WRITE_BYPASS_EN
        exp_same = 8'h3C;
`else
        exp_same = 8'h11;
`endif
        req_a(1'b0, 1'b0, 8'd0, 8'd0);
        req_b(1'b0, 1'b0, 4'd0, 16'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        check("a_rst_busy",   {31'd0, bus_a.Busy},      32'd1);
        check("a_rst_rdata",  {24'd0, bus_a.ReadData},  32'd0);
        check("a_rst_valid",  {31'd0, bus_a.ReadValid}, 32'd0);
        check("a_rst_aerr",   {31'd0, bus_a.AddrError}, 32'd0);
        count_busy_a(cycles);
        check("a_clear_len",  cycles, 32'd32);

        // back-to-back reads of the whole cleared array
        for (int a = 0; a < 32; a++) begin
            req_a(1'b1, 1'b0, 8'(a), 8'd0);
            tick();
            check("a_clr_rd_valid", {31'd0, bus_a.ReadValid}, 32'd1);
            check("a_clr_rd_data",  {24'd0, bus_a.ReadData},  32'd0);
        end
        req_a(1'b0, 1'b0, 8'd0, 8'd0);
        tick();
        check("a_valid_pulse", {31'd0, bus_a.ReadValid}, 32'd0);

        req_a(1'b0, 1'b1, 8'd7, 8'hA5);
        tick();
        check("a_wr_no_valid", {31'd0, bus_a.ReadValid}, 32'd0);
        req_a(1'b1, 1'b0, 8'd7, 8'h00);
        tick();
        check("a_rd7_valid", {31'd0, bus_a.ReadValid}, 32'd1);
        check("a_rd7_data",  {24'd0, bus_a.ReadData},  32'hA5);

        req_a(1'b0, 1'b1, 8'd4, 8'h11);
        tick();
        req_a(1'b1, 1'b1, 8'd4, 8'h3C);
        tick();
        check("a_collide_data",  {24'd0, bus_a.ReadData},  {24'd0, exp_same});
        check("a_collide_valid", {31'd0, bus_a.ReadValid}, 32'd1);
        req_a(1'b1, 1'b0, 8'd4, 8'h00);
        tick();
        check("a_after_collide", {24'd0, bus_a.ReadData}, 32'h3C);

        req_a(1'b0, 1'b1, 8'd8, 8'h22);
        tick();
        req_a(1'b0, 1'b1, 8'd40, 8'hFF);
        tick();
        check("a_oor_wr_aerr",  {31'd0, bus_a.AddrError}, 32'd1);
        check("a_oor_wr_valid", {31'd0, bus_a.ReadValid}, 32'd0);
        check("a_oor_wr_rdata", {24'd0, bus_a.ReadData},  32'h3C);
        req_a(1'b1, 1'b0, 8'd8, 8'h00);
        tick();
        check("a_rd8_data", {24'd0, bus_a.ReadData},  32'h22);
        check("a_rd8_aerr", {31'd0, bus_a.AddrError}, 32'd0);
        req_a(1'b1, 1'b0, 8'd200, 8'h00);
        tick();
        check("a_oor_rd_aerr",  {31'd0, bus_a.AddrError}, 32'd1);
        check("a_oor_rd_valid", {31'd0, bus_a.ReadValid}, 32'd0);
        check("a_oor_rd_rdata", {24'd0, bus_a.ReadData},  32'h22);
        req_a(1'b0, 1'b0, 8'd0, 8'h00);
        tick();
        check("a_aerr_pulse", {31'd0, bus_a.AddrError}, 32'd0);

        // reset right after a write: contents must be cleared again
        req_a(1'b0, 1'b1, 8'd2, 8'h55);
        tick();
        req_a(1'b1, 1'b0, 8'd2, 8'h00);
        tick();
        check("a_rd2_pre", {24'd0, bus_a.ReadData}, 32'h55);
        req_a(1'b0, 1'b0, 8'd0, 8'h00);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("a_rst2_rdata", {24'd0, bus_a.ReadData}, 32'd0);
        check("a_rst2_busy",  {31'd0, bus_a.Busy},     32'd1);
        req_a(1'b1, 1'b0, 8'd2, 8'h00);
        count_busy_a(cycles);
        check("a_clear2_len", cycles, 32'd32);
        req_a(1'b1, 1'b0, 8'd2, 8'h00);
        tick();
        check("a_rd2_post", {24'd0, bus_a.ReadData}, 32'd0);

        // reset again at cycle 10 of a clear, with requests during busy
        req_a(1'b0, 1'b0, 8'd0, 8'h00);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        req_a(1'b1, 1'b1, 8'd5, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            check("a_mid_busy",  {31'd0, bus_a.Busy}, 32'd1);
            check("a_mid_flags", {30'd0, bus_a.ReadValid, bus_a.AddrError}, 32'd0);
            tick();
        end
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        req_a(1'b1, 1'b0, 8'd40, 8'h00);
        count_busy_a(cycles);
        check("a_clear3_len", cycles, 32'd32);
        req_a(1'b1, 1'b0, 8'd5, 8'h00);
        tick();
        check("a_rd5_valid", {31'd0, bus_a.ReadValid}, 32'd1);
        check("a_rd5_data",  {24'd0, bus_a.ReadData},  32'd0);
        req_a(1'b0, 1'b0, 8'd0, 8'h00);

        // 16-bit / 10-word instance
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        count_busy_b(cycles);
        check("b_clear_len", cycles, 32'd10);
        req_b(1'b0, 1'b1, 4'd9, 16'hBEEF);
        tick();
        req_b(1'b1, 1'b0, 4'd9, 16'h0000);
        tick();
        check("b_rd9_data",  {16'd0, bus_b.ReadData},  32'hBEEF);
        check("b_rd9_valid", {31'd0, bus_b.ReadValid}, 32'd1);
        req_b(1'b1, 1'b0, 4'd10, 16'h0000);
        tick();
        check("b_rd10_aerr",  {31'd0, bus_b.AddrError}, 32'd1);
        check("b_rd10_valid", {31'd0, bus_b.ReadValid}, 32'd0);
        check("b_rd10_rdata", {16'd0, bus_b.ReadData},  32'hBEEF);
        req_b(1'b0, 1'b1, 4'd15, 16'h1234);
        tick();
        check("b_wr15_aerr", {31'd0, bus_b.AddrError}, 32'd1);
        req_b(1'b0, 1'b0, 4'd0, 16'h0000);
        tick();
        check("b_aerr_pulse", {31'd0, bus_b.AddrError}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
